unidade_load_store: RTL and testbench
=====================================

# unidade_load_store

Load/store unit for the single-cycle-plus-memory RISC-V datapath. It sits directly downstream of the ALU. It takes the effective address computed by the ALU (`resultado` of an add: base + offset) and carries out the `lh`/`sh` access on the data-memory bus with a request/acknowledge handshake. It returns the sign-extended halfword for `lh` and signals completion to the control unit.

## Interface
Parameters:
- `TIMEOUT_CICLOS`, default 15: maximum cycles `mem_req` waits for `mem_ack`. Used only when `LSU_TIMEOUT_EN` is defined.

Ports:
- `clock`  in  1  single clock; all state changes on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `inicio`  in  1  start strobe; accepted only in OCIOSO
- `eh_escrita`  in  1  1 = `sh`, 0 = `lh`; sampled with `inicio`
- `endereco`  in  32  effective byte address from ALU `resultado`; sampled with `inicio`
- `dado_escrita`  in  32  rs2 value; bits [15:0] are stored; sampled with `inicio`
- `ocupado`  out  1  high whenever state ≠ OCIOSO
- `concluido`  out  1  one-cycle completion pulse
- `dado_lido`  out  32  sign-extended halfword from the last successful `lh`
- `erro_alinhamento`  out  1  pulses with `concluido` when `endereco[0]`=1
- `erro_timeout`  out  1  pulses with `concluido` on bus timeout
- `mem_req`  out  1  bus request
- `mem_we`  out  1  bus write enable
- `mem_end`  out  32  word address, `{endereco[31:2], 2'b00}`
- `mem_wdata`  out  32  `{dado_escrita[15:0], dado_escrita[15:0]}`
- `mem_be`  out  4  byte enables: 4'b0011 if `endereco[1]`=0, 4'b1100 otherwise; 4'b0000 for reads
- `mem_rdata`  in  32  read data; valid in the `mem_ack` cycle
- `mem_ack`  in  1  bus acknowledge

## Operation
- FSM states: OCIOSO, REQUISICAO, FIM.
- **OCIOSO:**
  - On `inicio`=1, latch `eh_escrita`, `endereco`, `dado_escrita`.
  - If `endereco[0]`=1, go to FIM with the misalignment flag set and issue no bus cycle.
  - Otherwise go to REQUISICAO.
- **REQUISICAO:**
  - `mem_req`=1. `mem_we`, `mem_end`, `mem_wdata` and `mem_be` are driven from the latched registers and stay stable until ack.
  - On `mem_ack`=1 for a read, capture the halfword: `mem_rdata[15:0]` if latched `endereco[1]`=0, else `mem_rdata[31:16]`.
  - Sign-extend bit 15 into `dado_lido`, then go to FIM.
- **FIM:**
  - `concluido`=1 for exactly one cycle. Error flags assert in the same cycle only when set.
  - Unconditionally return to OCIOSO.
- `inicio` is ignored while `ocupado`=1. It is never queued.
- `mem_ack` is ignored outside REQUISICAO.
- `dado_lido` changes only on a successful `lh`. Writes, misaligned accesses and timeouts leave it unchanged.
- All `mem_*` outputs are 0 outside REQUISICAO.
- Reset (`reset_n`=0, any state):
  - State returns to OCIOSO.
  - All outputs go to 0, including `dado_lido`, asynchronously.
  - An in-flight request is abandoned, and an ack arriving after reset is ignored.

## Timing
- `inicio` sampled at edge 0.
- `mem_req` is high from edge 0 until the edge that samples `mem_ack`=1.
- With ack in the first request cycle, `concluido` is high in the cycle after edge 1: 2 cycles from `inicio` to done.
- Each extra wait cycle of the bus adds one cycle.
- Misaligned access: `concluido` and `erro_alinhamento` are high in the cycle after edge 0, with `mem_req` never asserted.
- A new `inicio` is accepted in the cycle after the `concluido` pulse. Back-to-back throughput is one access per 3 cycles at zero wait.

## Configuration
- Macro `LSU_TIMEOUT_EN`, defined:
  - A 5-bit counter clears on entry to REQUISICAO and increments on each cycle there without ack.
  - When the counter reaches `TIMEOUT_CICLOS`, the unit drops `mem_req` and goes to FIM with `erro_timeout`=1.
  - An ack in that same cycle wins: normal completion, no error.
- Not defined:
  - No counter is built, and REQUISICAO waits indefinitely.
  - `erro_timeout` is tied to 0.

## Test plan
- `lh`, `endereco`=0x00000006, bus returns `mem_rdata`=0x8001_1234 with ack on the first request cycle → `mem_end`=0x4, `mem_be`=4'b0000, `dado_lido`=0xFFFF_8001, `concluido` 2 cycles after `inicio`.
- `sh`, `endereco`=0x10, `dado_escrita`=0xDEAD_BEEF, ack after 3 wait cycles → `mem_we`=1, `mem_be`=4'b0011, `mem_wdata`=0xBEEF_BEEF held stable for 4 cycles, `dado_lido` unchanged.
- `lh`, `endereco`=0x3 → `concluido`=1 and `erro_alinhamento`=1 at cycle 1, `mem_req` never high.
- `inicio` pulsed again while `ocupado`, with a different address → ignored; the bus keeps the first address and only one `concluido` is produced.
- `reset_n` dropped during REQUISICAO, then ack applied after release → `mem_req`=0 immediately, state OCIOSO, no `concluido`, `dado_lido`=0.
- With `LSU_TIMEOUT_EN` and `TIMEOUT_CICLOS`=15, no ack → `mem_req` drops after 15 request cycles and `concluido`+`erro_timeout` pulse once. Without the macro → `mem_req` is still high after 100 cycles.

Source files
------------

// File: rtl/unidade_load_store.sv
// Load/store unit: lh/sh halfword accesses on a req/ack data bus, sign-extended read-back.
// Optional bus timeout is built only when LSU_TIMEOUT_EN is defined.
module unidade_load_store #(
  parameter int TIMEOUT_CICLOS = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inicio,
  input  logic        eh_escrita,
  input  logic [31:0] endereco,
  input  logic [31:0] dado_escrita,
  output logic        ocupado,
  output logic        concluido,
  output logic [31:0] dado_lido,
  output logic        erro_alinhamento,
  output logic        erro_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_end,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // Bus handshake: mem_req rises with the latched request and holds mem_we/mem_end/
  // mem_wdata/mem_be stable until the edge that samples mem_ack=1, then all drop to 0.
  typedef enum logic [1:0] {OCIOSO, REQUISICAO, FIM} estado_t;

  estado_t     estado;
  logic        meia_alta;
  logic        estouro;
  logic [15:0] meia_lida;
  logic        unused_bits;

  assign ocupado     = (estado != OCIOSO);
  assign meia_lida   = meia_alta ? mem_rdata[31:16] : mem_rdata[15:0];
  assign unused_bits = ^dado_escrita[31:16];

`ifdef LSU_TIMEOUT_EN
  localparam logic [4:0] LIMITE = 5'(TIMEOUT_CICLOS);
  logic [4:0] cont;

  // estouro fires on the cycle whose unacked edge would bring cont up to LIMITE
  assign estouro = (estado == REQUISICAO) && !mem_ack && (cont == LIMITE - 5'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cont         <= 5'd0;
      erro_timeout <= 1'b0;
    end else begin
      erro_timeout <= estouro;
      if (estado != REQUISICAO)
        cont <= 5'd0;
      else if (!mem_ack)
        cont <= cont + 5'd1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CICLOS;
  assign estouro      = 1'b0;
  assign erro_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado           <= OCIOSO;
      meia_alta        <= 1'b0;
      concluido        <= 1'b0;
      erro_alinhamento <= 1'b0;
      dado_lido        <= 32'd0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_end          <= 32'd0;
      mem_wdata        <= 32'd0;
      mem_be           <= 4'd0;
    end else begin
      case (estado)
        OCIOSO: begin
          concluido        <= 1'b0;
          erro_alinhamento <= 1'b0;
          if (inicio) begin
            meia_alta <= endereco[1];
            if (endereco[0]) begin
              estado           <= FIM;
              concluido        <= 1'b1;
              erro_alinhamento <= 1'b1;
            end else begin
              estado    <= REQUISICAO;
              mem_req   <= 1'b1;
              mem_we    <= eh_escrita;
              mem_end   <= {endereco[31:2], 2'b00};
              mem_wdata <= {dado_escrita[15:0], dado_escrita[15:0]};
              mem_be    <= eh_escrita ? (endereco[1] ? 4'b1100 : 4'b0011) : 4'b0000;
            end
          end
        end
        REQUISICAO: begin
          if (mem_ack || estouro) begin
            estado    <= FIM;
            concluido <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_end   <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
            if (mem_ack && !mem_we)
              dado_lido <= {{16{meia_lida[15]}}, meia_lida};
          end
        end
        FIM: begin
          estado           <= OCIOSO;
          concluido        <= 1'b0;
          erro_alinhamento <= 1'b0;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_load_store.sv
// Randomized scoreboard bench for unidade_load_store with a bus responder and
// a halfword-level reference model.
module tb_unidade_load_store;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        inicio = 1'b0;
  logic        eh_escrita = 1'b0;
  logic [31:0] endereco = 32'd0;
  logic [31:0] dado_escrita = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        ack_r = 1'b0;
  logic        ack_x = 1'b0;
  logic        mem_ack;
  logic        ocupado, concluido, erro_alinhamento, erro_timeout;
  logic        mem_req, mem_we;
  logic [31:0] dado_lido, mem_end, mem_wdata;
  logic [3:0]  mem_be;

  assign mem_ack = ack_r | ack_x;

  unidade_load_store #(.TIMEOUT_CICLOS(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .inicio(inicio), .eh_escrita(eh_escrita),
    .endereco(endereco), .dado_escrita(dado_escrita), .ocupado(ocupado),
    .concluido(concluido), .dado_lido(dado_lido), .erro_alinhamento(erro_alinhamento),
    .erro_timeout(erro_timeout), .mem_req(mem_req), .mem_we(mem_we), .mem_end(mem_end),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // clock / reset block
  always #5 clock = ~clock;
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string nome, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] ender;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [41:0] exp_q[$];   // {latency[7:0], erro_alinhamento, erro_timeout, dado_lido}
  int unsigned issue_q[$];
  logic [31:0] model_lido = 32'd0;

  function automatic logic [31:0] sext_half(input logic [31:0] rdata, input logic alto);
    int h;
    h = alto ? int'(rdata >> 16) : int'(rdata & 32'hFFFF);
    if (h >= 32768) h = h - 65536;
    return 32'(h);
  endfunction

  // driver tasks
  task automatic esperar_ocioso();
    int n;
    n = 0;
    @(negedge clock);
    while (ocupado && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (ocupado) check("espera_ocioso", 64'(ocupado), 64'd0);
  endtask

  task automatic pulso(input logic we, input logic [31:0] addr, input logic [31:0] d);
    inicio = 1'b1;
    eh_escrita = we;
    endereco = addr;
    dado_escrita = d;
    @(posedge clock);
    #1;
    inicio = 1'b0;
    eh_escrita = 1'($urandom_range(0, 1));
    endereco = $urandom;
    dado_escrita = $urandom;
  endtask

  task automatic emitir(input logic we, input logic [31:0] addr, input logic [31:0] d,
                        input int waits, input logic [31:0] rdata, input bit extra);
    bus_t b;
    int lat;
    logic to;
    esperar_ocioso();
    to = 1'b0;
    if (addr[0]) begin
      lat = 1;
    end else begin
      b.we = we;
      b.be = we ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0000;
      b.ender = addr & ~32'h3;
      b.wdata = {d[15:0], d[15:0]};
      b.waits = waits;
      b.rdata = rdata;
      bus_q.push_back(b);
      if (waits < 0) begin
        lat = 1 + TIMEOUT;
        to = 1'b1;
      end else begin
        lat = 2 + waits;
        if (!we) model_lido = sext_half(rdata, addr[1]);
      end
    end
    exp_q.push_back({8'(lat), addr[0], to, model_lido});
    issue_q.push_back(cyc + 1);
    pulso(we, addr, d);
    if (extra) begin
      @(negedge clock);
      pulso(~we, addr ^ 32'h100, ~d);
    end
  endtask

  task automatic reset_meio();
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_ocupado", 64'(ocupado), 64'd0);
    check("rst_concluido", 64'(concluido), 64'd0);
    check("rst_dado_lido", 64'(dado_lido), 64'd0);
    check("rst_mem_be", 64'(mem_be), 64'd0);
    model_lido = 32'd0;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  // bus responder: checks the request fields every cycle and acks after the planned waits
  bus_t cur;
  int   w = 0;
  bit   em_curso = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      em_curso = 1'b0;
      ack_r = 1'b0;
    end else if (mem_req) begin
      if (!em_curso) begin
        em_curso = 1'b1;
        if (bus_q.size() == 0) begin
          check("req_inesperado", 64'(mem_req), 64'd0);
          cur.we = 1'b0; cur.be = 4'd0; cur.ender = 32'd0; cur.wdata = 32'd0;
          cur.waits = -1; cur.rdata = 32'd0;
        end else begin
          cur = bus_q.pop_front();
        end
        w = cur.waits;
      end
      check("mem_we", 64'(mem_we), 64'(cur.we));
      check("mem_be", 64'(mem_be), 64'(cur.be));
      check("mem_end", 64'(mem_end), 64'(cur.ender));
      if (cur.we) check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
      if (w == 0) begin
        ack_r = 1'b1;
        mem_rdata = cur.rdata;
      end else begin
        ack_r = 1'b0;
        mem_rdata = $urandom;
        if (w > 0) w--;
      end
    end else begin
      em_curso = 1'b0;
      ack_r = 1'b0;
      mem_rdata = $urandom;
      check("bus_ocioso", {28'd0, mem_we, mem_be, mem_end ^ mem_wdata}, 64'd0);
    end
  end

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset_n && concluido) begin
      if (exp_q.size() == 0 || issue_q.size() == 0) begin
        check("concluido_inesperado", 64'(concluido), 64'd0);
      end else begin
        logic [41:0] e;
        int unsigned t;
        e = exp_q.pop_front();
        t = issue_q.pop_front();
        check("latencia", 64'(cyc - t + 1), 64'(e[41:34]));
        check("erro_alinhamento", 64'(erro_alinhamento), 64'(e[33]));
        check("erro_timeout", 64'(erro_timeout), 64'(e[32]));
        check("dado_lido", 64'(dado_lido), 64'(e[31:0]));
      end
    end else if (reset_n && (erro_alinhamento || erro_timeout)) begin
      check("erro_sem_concluido", {62'd0, erro_alinhamento, erro_timeout}, 64'd0);
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    check("reset_ocupado", 64'(ocupado), 64'd0);
    check("reset_concluido", 64'(concluido), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_dado_lido", 64'(dado_lido), 64'd0);
    check("reset_erros", {62'd0, erro_alinhamento, erro_timeout}, 64'd0);
    reset_n = 1'b1;

    emitir(1'b0, 32'h0000_0006, 32'h0, 0, 32'h8001_1234, 1'b0);
    emitir(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3, $urandom, 1'b0);
    emitir(1'b0, 32'h0000_0003, 32'h0, 0, 32'h0, 1'b0);
    emitir(1'b1, 32'h0000_0042, 32'h1234_5678, 3, $urandom, 1'b1);

    // reset while a read is waiting, then a stray ack once idle
    esperar_ocioso();
    begin
      bus_t b;
      b.we = 1'b0; b.be = 4'b0000; b.ender = 32'h20; b.wdata = 32'h0;
      b.waits = -1; b.rdata = 32'h0;
      bus_q.push_back(b);
    end
    pulso(1'b0, 32'h20, 32'h0);
    repeat (2) @(posedge clock);
    reset_meio();
    @(negedge clock);
    ack_x = 1'b1;
    repeat (3) @(negedge clock);
    ack_x = 1'b0;
    check("pos_reset_ocupado", 64'(ocupado), 64'd0);

`ifdef LSU_TIMEOUT_EN
    emitir(1'b0, 32'h0000_0100, 32'h0, -1, 32'h0, 1'b0);
`else
    esperar_ocioso();
    begin
      bus_t b;
      b.we = 1'b1; b.be = 4'b1100; b.ender = 32'h100; b.wdata = 32'hCAFE_CAFE;
      b.waits = -1; b.rdata = 32'h0;
      bus_q.push_back(b);
    end
    pulso(1'b1, 32'h102, 32'h0000_CAFE);
    repeat (100) @(negedge clock);
    check("sem_timeout_mem_req", 64'(mem_req), 64'd1);
    reset_meio();
`endif

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
      emitir(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 4)), $urandom, 1'b0);
    end

    begin
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 300) begin
        @(negedge clock);
        n++;
      end
    end
    repeat (2) @(negedge clock);
    check("exp_q_vazia", 64'(exp_q.size()), 64'd0);
    check("bus_q_vazia", 64'(bus_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
